alu_issue_8: RTL and testbench

ALU_ISSUE_8 -- requirements
Module: alu_issue_8

---
 rtl/alu_issue_8.sv | 186 ++++++++++++++++++
 tb/tb_alu_issue_8.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_8.sv
// alu_issue_8: issue stage in front of an external combinational ALU.
// Op-words {A, B, Op[, UseAcc]} are queued in a DEPTH-entry FIFO. The head
// entry drives the ALU operands, and its result is captured into an output
// register that uses a valid/ready handshake.
//
// Build option: define ALU_ACC_FWD_EN to add an 8-bit accumulator. The
// accumulator loads AluResult on every issue. A head entry with UseAcc=1
// then takes the accumulator as operand A.
//
// Ports:
//   Clk, Rst_n            clock, synchronous active-low reset
//   InValid/InReady       upstream handshake; InReady = (Count != DEPTH)
//   InA, InB, InOp        operands and op code
//   InUseAcc              select accumulator as A (ALU_ACC_FWD_EN only)
//   AluA, AluB, AluOp     operands driven to the ALU (zero when FIFO empty)
//   AluResult, AluCout    combinational ALU response
//   OutValid/OutReady     downstream handshake
//   OutResult, OutCout,   registered result, carry, and zero flag
//   OutZero
//   Count                 FIFO occupancy
module alu_issue_8 #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [7:0]               InA,
  input  logic [7:0]               InB,
  input  logic [2:0]               InOp,
  input  logic                     InUseAcc,
  output logic [7:0]               AluA,
  output logic [7:0]               AluB,
  output logic [2:0]               AluOp,
  input  logic [7:0]               AluResult,
  input  logic                     AluCout,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [7:0]               OutResult,
  output logic                     OutCout,
  output logic                     OutZero,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0] a_mem  [DEPTH];
  logic [7:0] b_mem  [DEPTH];
  logic [2:0] op_mem [DEPTH];

`ifdef ALU_ACC_FWD_EN
  logic       use_mem [DEPTH];
  logic [7:0] acc_q, acc_d;
`else
  // InUseAcc has no function in this build.
  logic unused_use_acc;
  assign unused_use_acc = InUseAcc;
`endif

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_result_q, out_result_d;
  logic          out_cout_q, out_cout_d;
  logic          out_zero_q, out_zero_d;

  logic empty;
  logic push;
  logic issue;

  always_comb begin
    empty   = (count_q == '0);
    InReady = (count_q != FULL);
    push    = InValid && InReady;
    // The head may only move when the output register is free, or is being
    // drained on this same edge.
    issue   = !empty && (!out_valid_q || OutReady);
  end

  // ALU operands come straight from the FIFO head.
  always_comb begin
    AluA  = '0;
    AluB  = '0;
    AluOp = '0;
    if (!empty) begin
      AluA  = a_mem[rd_ptr_q];
      AluB  = b_mem[rd_ptr_q];
      AluOp = op_mem[rd_ptr_q];
`ifdef ALU_ACC_FWD_EN
      if (use_mem[rd_ptr_q]) begin
        AluA = acc_q;
      end
`endif
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_cout_d   = out_cout_q;
    out_zero_d   = out_zero_q;
`ifdef ALU_ACC_FWD_EN
    acc_d        = acc_q;
`endif

    // DEPTH is a power of two, so the pointers wrap naturally.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (issue) begin
      out_valid_d  = 1'b1;
      out_result_d = AluResult;
      out_cout_d   = AluCout;
      out_zero_d   = (AluResult == 8'h00);
`ifdef ALU_ACC_FWD_EN
      acc_d        = AluResult;
`endif
    end else if (out_valid_q && OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
      out_zero_q   <= 1'b0;
`ifdef ALU_ACC_FWD_EN
      acc_q        <= '0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_cout_q   <= out_cout_d;
      out_zero_q   <= out_zero_d;
`ifdef ALU_ACC_FWD_EN
      acc_q        <= acc_d;
`endif
    end
  end

  // Storage is not reset: the pointers and the count define which entries
  // are live.
  always_ff @(posedge Clk) begin
    if (Rst_n && push) begin
      a_mem[wr_ptr_q]   <= InA;
      b_mem[wr_ptr_q]   <= InB;
      op_mem[wr_ptr_q]  <= InOp;
`ifdef ALU_ACC_FWD_EN
      use_mem[wr_ptr_q] <= InUseAcc;
`endif
    end
  end

  always_comb begin
    OutValid  = out_valid_q;
    OutResult = out_result_q;
    OutCout   = out_cout_q;
    OutZero   = out_zero_q;
    Count     = count_q;
  end

endmodule

// File: tb/tb_alu_issue_8.sv
// Self-checking bench for alu_issue_8 (DEPTH=4).
// A behavioural ALU model answers the DUT's operand outputs. Each accepted
// push queues its expected {result, carry, zero}, and a monitor compares
// every consumed output against the head of that queue.
module tb_alu_issue_8;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       InValid;
  logic       InReady;
  logic [7:0] InA, InB;
  logic [2:0] InOp;
  logic       InUseAcc;
  logic [7:0] AluA, AluB;
  logic [2:0] AluOp;
  logic [7:0] AluResult;
  logic       AluCout;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] OutResult;
  logic       OutCout;
  logic       OutZero;
  logic [2:0] Count;

  alu_issue_8 #(.DEPTH(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .InValid(InValid), .InReady(InReady),
    .InA(InA), .InB(InB), .InOp(InOp), .InUseAcc(InUseAcc),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp),
    .AluResult(AluResult), .AluCout(AluCout),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutResult(OutResult), .OutCout(OutCout), .OutZero(OutZero),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  // ALU model: 000 add, 001 sub (A + ~B + 1), 010 and, 011 or, 100 xor,
  // and any other code passes A through.
  logic [8:0] alu_s;
  always_comb begin
    alu_s = '0;
    case (AluOp)
      3'b000:  alu_s = {1'b0, AluA} + {1'b0, AluB};
      3'b001:  alu_s = {1'b0, AluA} + {1'b0, ~AluB} + 9'd1;
      3'b010:  alu_s = {1'b0, AluA & AluB};
      3'b011:  alu_s = {1'b0, AluA | AluB};
      3'b100:  alu_s = {1'b0, AluA ^ AluB};
      default: alu_s = {1'b0, AluA};
    endcase
    AluResult = alu_s[7:0];
    AluCout   = alu_s[8];
  end

  typedef struct {
    logic [7:0] res;
    logic       cout;
    logic       zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // An output is consumed at the coming edge when OutValid && OutReady
  // with reset released, so inspect it at the falling edge before that.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n && OutValid && OutReady) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_result: actual %0h required none", OutResult);
        end else begin
          e = exp_q.pop_front();
          if (OutResult !== e.res || OutCout !== e.cout || OutZero !== e.zero) begin
            n_bad++;
            $display("FAIL result: actual res=%0h c=%0b z=%0b required res=%0h c=%0b z=%0b",
                     OutResult, OutCout, OutZero, e.res, e.cout, e.zero);
          end
        end
      end
    end
  endtask

  // Present one op for a single cycle. It is expected to be accepted, and
  // its result is queued.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic use_acc, input logic [7:0] r, input logic c);
    exp_t e;
    int   waited = 0;
    while (!InReady && waited < 20) begin
      tick();
      waited++;
    end
    check("push_ready", InReady, 1);
    InA = a; InB = b; InOp = op; InUseAcc = use_acc; InValid = 1'b1;
    if (InReady) begin
      e.res = r; e.cout = c; e.zero = (r == 8'h00);
      exp_q.push_back(e);
    end
    tick();
    InValid = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    Rst_n = 1'b0; InValid = 1'b0; InA = '0; InB = '0; InOp = '0;
    InUseAcc = 1'b0; OutReady = 1'b0;
    tick(); tick();
    Rst_n = 1'b1;

    // Reset state.
    check("rst_count", Count, 0);
    check("rst_inready", InReady, 1);
    check("rst_outvalid", OutValid, 0);
    check("rst_outresult", OutResult, 0);
    check("rst_outcout", OutCout, 0);
    check("rst_outzero", OutZero, 0);
    check("rst_alu_ops", {AluA, AluB, 5'(AluOp)}, 0);

    // Single op and its latency.
    OutReady = 1'b1;
    push(8'h05, 8'h03, 3'b000, 1'b0, 8'h08, 1'b0);
    check("lat_count", Count, 1);
    check("lat_outvalid_early", OutValid, 0);
    check("head_alu_ab", {AluA, AluB}, 16'h0503);
    tick();
    check("single_valid", OutValid, 1);
    check("single_res", {OutResult, 7'(OutCout), 1'(OutZero)}, {8'h08, 7'd0, 1'b0});
    tick();
    check("single_valid_fall", OutValid, 0);

    // Carry and zero.
    push(8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1'b1);
    tick();
    check("cz_flags", {OutResult, 7'(OutCout), 1'(OutZero)}, {8'h00, 7'd1, 1'b1});
    tick();

    // Fill under backpressure. The first op moves into the idle output
    // register, so five pushes leave four in the FIFO. A sixth is refused.
    OutReady = 1'b0;
    push(8'h01, 8'h01, 3'b000, 1'b0, 8'h02, 1'b0);
    push(8'h10, 8'h03, 3'b001, 1'b0, 8'h0D, 1'b1);
    push(8'hF0, 8'h3C, 3'b010, 1'b0, 8'h30, 1'b0);
    push(8'h0F, 8'hF0, 3'b100, 1'b0, 8'hFF, 1'b0);
    push(8'h80, 8'h80, 3'b000, 1'b0, 8'h00, 1'b1);
    check("full_count", Count, 4);
    check("full_inready", InReady, 0);
    InA = 8'hAA; InB = 8'h55; InOp = 3'b011; InValid = 1'b1;
    tick();
    check("full_push_ignored", Count, 4);
    // Push attempt in the same cycle as a pop, while full.
    OutReady = 1'b1;
    tick();
    InValid = 1'b0;
    check("full_pop_no_push", Count, 3);
    drain("fill_drain");
    tick();
    check("fill_valid_fall", OutValid, 0);
    check("fill_empty", Count, 0);

    // Backpressure toggling with three queued ops.
    OutReady = 1'b0;
    push(8'h33, 8'h11, 3'b001, 1'b0, 8'h22, 1'b1);
    push(8'h0C, 8'h0A, 3'b011, 1'b0, 8'h0E, 1'b0);
    push(8'h07, 8'h09, 3'b000, 1'b0, 8'h10, 1'b0);
    OutReady = 1'b1; tick();
    OutReady = 1'b0; tick();
    check("bp_hold_valid", OutValid, 1);
    tick();
    OutReady = 1'b1;
    drain("bp_drain");
    tick();
    check("bp_valid_fall", OutValid, 0);

    // Reset mid-stream discards the queued ops and the pending result.
    OutReady = 1'b0;
    push(8'h01, 8'h02, 3'b000, 1'b0, 8'h03, 1'b0);
    push(8'h01, 8'h03, 3'b000, 1'b0, 8'h04, 1'b0);
    push(8'h01, 8'h04, 3'b000, 1'b0, 8'h05, 1'b0);
    push(8'h01, 8'h05, 3'b000, 1'b0, 8'h06, 1'b0);
    check("mid_count", Count, 3);
    check("mid_valid", OutValid, 1);
    Rst_n = 1'b0; InValid = 1'b1; OutReady = 1'b1;
    exp_q.delete();
    tick();
    Rst_n = 1'b1; InValid = 1'b0;
    check("mrst_count", Count, 0);
    check("mrst_valid", OutValid, 0);
    check("mrst_out", {OutResult, 7'(OutCout), 1'(OutZero)}, 0);
    check("mrst_inready", InReady, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mrst_no_output", OutValid, 0);
    end

    // Accumulator forwarding.
    push(8'h10, 8'h01, 3'b000, 1'b0, 8'h11, 1'b0);
`ifdef ALU_ACC_FWD_EN
    push(8'h00, 8'h02, 3'b000, 1'b1, 8'h13, 1'b0);
`else
    push(8'h00, 8'h02, 3'b000, 1'b1, 8'h02, 1'b0);
`endif
    drain("acc_drain");
    tick();
    check("final_valid", OutValid, 0);
    check("final_count", Count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
